// File: rtl/pc_jump_unit.sv
// Fetch-control stage of the 16-bit Hack CPU: holds PC and A, decodes the
// C-instruction jump field against the ALU flags and selects the next PC.

module hack_reg #(
    parameter int          WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= RESET_VAL;
        else if (load)
            q <= d;
    end
endmodule

module pc_jump_unit #(
    parameter logic [15:0] PC_RESET = 16'h0000,
    parameter logic [15:0] A_RESET  = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [15:0] instr,
    input  logic [15:0] alu_out,
    input  logic        zr,
    input  logic        ng,
    output logic [15:0] pc,
    output logic [15:0] a_reg,
    output logic        jumped
);
    logic        is_c;
    logic        pos;
    logic        take;
    logic        a_load;
    logic [15:0] a_next;
    logic [15:0] pc_next;
    logic [0:0]  jumped_next;
    logic [0:0]  jumped_q;

    // Flags are evaluated literally; zr & ng together is never filtered.
    always_comb begin
        is_c        = instr[15];
        pos         = ~zr & ~ng;
        take        = is_c & ((instr[2] & ng) | (instr[1] & zr) | (instr[0] & pos));
        a_load      = ~stall & (~is_c | instr[5]);
        a_next      = is_c ? alu_out : instr;
        // Jump target is the A value before this edge, never a same-cycle A write.
        pc_next     = take ? a_reg : pc + 16'd1;
        jumped_next = take;
    end

    hack_reg #(.WIDTH(16), .RESET_VAL(PC_RESET)) u_pc (
        .clk   (clk),
        .reset (reset),
        .load  (~stall),
        .d     (pc_next),
        .q     (pc)
    );

    hack_reg #(.WIDTH(16), .RESET_VAL(A_RESET)) u_a (
        .clk   (clk),
        .reset (reset),
        .load  (a_load),
        .d     (a_next),
        .q     (a_reg)
    );

    hack_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_jumped (
        .clk   (clk),
        .reset (reset),
        .load  (~stall),
        .d     (jumped_next),
        .q     (jumped_q)
    );

    assign jumped = jumped_q[0];
endmodule

// File: doc/pc_jump_unit.md
Name: pc_jump_unit

Overview:
Instruction-fetch control stage of the 16-bit Hack-style CPU. Holds the program counter (PC) and the A register. Decodes the jump field of C-instructions against the ALU flags and selects the next PC. Sits between the ALU/decode logic (upstream) and instruction ROM addressing (downstream). A and PC are built from the team's 16-bit load-enabled register primitives.

Parameters:
PC_RESET, 16'h0000, PC value loaded on reset.
A_RESET, 16'h0000, A register value loaded on reset.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
stall  input  1  1 = freeze PC, A and jumped for this cycle.
instr  input  16  current instruction word from ROM.
alu_out  input  16  ALU result for the current C-instruction.
zr  input  1  ALU flag: alu_out == 0.
ng  input  1  ALU flag: alu_out[15] == 1.
pc  output  16  registered program counter; drives ROM address.
a_reg  output  16  registered A register; drives data-memory address and jump target.
jumped  output  1  registered; 1 if the previous non-stalled cycle took a jump.

Behaviour:
Reset and stall:
- Reset is asynchronous, active-high, and the same cycle it asserts: pc = PC_RESET, a_reg = A_RESET, jumped = 0.
- Reset has priority over everything, including stall.
- Reset asserted mid-operation discards any pending update.
- Release of reset takes effect on the next rising edge only.
- stall = 1 (reset low): pc, a_reg and jumped hold their values; instr and flags are ignored.

Decode:
- A-instruction when instr[15] = 0; C-instruction when instr[15] = 1.
- Jump bits: j1 = instr[2] (out < 0), j2 = instr[1] (out = 0), j3 = instr[0] (out > 0).
- Destination bit for A: d1 = instr[5].
- pos = ~zr & ~ng.
- take = instr[15] & ((j1 & ng) | (j2 & zr) | (j3 & pos)).
- An A-instruction never jumps, whatever instr[2:0] holds.

A register update (each non-stalled edge):
- A-instruction: a_reg <= instr (bit 15 is 0 by definition).
- C-instruction with d1 = 1: a_reg <= alu_out.
- Otherwise a_reg holds.

PC update (each non-stalled edge):
- take = 1: pc <= the a_reg value before this edge. The jump target is the old A, not an alu_out written to A in the same cycle.
- Otherwise pc <= pc + 1, modulo 2^16 (16'hFFFF wraps to 16'h0000, no flag).
- jumped <= take.

Timing and flag rules:
- Latency: one cycle from instr/flags to the pc/a_reg update. No combinational path from inputs to outputs.
- Unconditional jump (instr[2:0] = 3'b111) is taken for any flag values.
- Null jump (instr[2:0] = 3'b000) never jumps.
- The flags zr = 1 and ng = 1 together are illegal from the ALU. The block evaluates them literally and does not check for them.
- Jump to the current pc (a_reg == pc) is legal and produces a tight loop.

Test Plan:
- Reset then run: assert reset mid-run with pc = 16'h0042; pc and a_reg go to 0 immediately, before any clock edge. Release reset, apply 3 edges of C-instructions with instr = 16'hEA80 (no dest, no jump) -> pc = 1, 2, 3; jumped = 0.
- A-load then unconditional jump: instr = 16'h0100 -> a_reg = 16'h0100, pc + 1. Next instr = 16'hEA87 -> pc = 16'h0100, jumped = 1.
- Conditional jumps, with a_reg = 16'h0020 and each applied from a fresh pc:
  - JGT (instr[2:0] = 3'b001) with zr = 0, ng = 0 -> pc = 16'h0020.
  - JGT with zr = 1 -> pc + 1.
  - JLT (3'b100) with ng = 1 -> pc = 16'h0020.
  - JNE (3'b101) with zr = 1 -> pc + 1.
- Same-cycle A write and jump: a_reg = 16'h0010, instr = C-instruction with d1 = 1 and jump 3'b111, alu_out = 16'h0077 -> pc = 16'h0010, a_reg = 16'h0077.
- Stall and wrap: stall = 1 for 4 cycles with jumping instructions -> pc, a_reg and jumped unchanged. Then force pc = 16'hFFFF via a jump, stall = 0 with no jump -> pc = 16'h0000.
- A-instruction with low bits 3'b111 (instr = 16'h0007) and zr = 1 -> no jump, a_reg = 16'h0007, pc + 1, jumped = 0.
